// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA scan-out path.
//   - Default 640x480@60 horizontal/vertical timing and the sync bounds derived from it.
//   - Frame-buffer geometry and read-address width.
//   - RGB444 colours of the eight test-pattern bars, with helpers that map a column to its bar colour.
//   The test-pattern helpers are used only when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

    // Horizontal timing, pixels
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;

    // Vertical timing, lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    // Frame buffer (QVGA, shown 2x upscaled)
    localparam int FB_W   = 320;
    localparam int FB_H   = 240;
    localparam int FB_AW  = $clog2(FB_W * FB_H);

    // Datapath widths and default BRAM read latency
    localparam int CNT_W      = 10;
    localparam int PIX_W      = 12;
    localparam int RD_LAT_DEF = 1;

    // Test-pattern bar colours, RGB444, left to right
    localparam logic [PIX_W-1:0] BAR_WHITE   = 12'hFFF;
    localparam logic [PIX_W-1:0] BAR_YELLOW  = 12'hFF0;
    localparam logic [PIX_W-1:0] BAR_CYAN    = 12'h0FF;
    localparam logic [PIX_W-1:0] BAR_GREEN   = 12'h0F0;
    localparam logic [PIX_W-1:0] BAR_MAGENTA = 12'hF0F;
    localparam logic [PIX_W-1:0] BAR_RED     = 12'hF00;
    localparam logic [PIX_W-1:0] BAR_BLUE    = 12'h00F;
    localparam logic [PIX_W-1:0] BAR_BLACK   = 12'h000;

    // Bars are 80 px wide, so a power-of-two slice of the column does not line up with them.
    function automatic logic [2:0] barIndex(input logic [CNT_W-1:0] x);
        logic [2:0] idx;
        if      (x < 10'd80)  idx = 3'd0;
        else if (x < 10'd160) idx = 3'd1;
        else if (x < 10'd240) idx = 3'd2;
        else if (x < 10'd320) idx = 3'd3;
        else if (x < 10'd400) idx = 3'd4;
        else if (x < 10'd480) idx = 3'd5;
        else if (x < 10'd560) idx = 3'd6;
        else                  idx = 3'd7;
        return idx;
    endfunction

    function automatic logic [PIX_W-1:0] barColour(input logic [2:0] bar);
        logic [PIX_W-1:0] c;
        case (bar)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            3'd7:    c = BAR_BLACK;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Horizontal/vertical raster counters plus the undelayed timing flags derived from them.
//   Ports:
//     clk25     in   pixel clock
//     rstN      in   synchronous active-low reset (counters to 0,0)
//     hCount    out  column 0..H_TOTAL-1
//     vCount    out  line   0..V_TOTAL-1
//     active    out  visible area flag (combinational)
//     hsyncRaw  out  active-low hsync, undelayed (combinational)
//     vsyncRaw  out  active-low vsync, undelayed (combinational)
//     frameDone out  registered, high exactly while the counters sit at (0, V_ACTIVE)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk25,
    input  logic             rstN,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             active,
    output logic             hsyncRaw,
    output logic             vsyncRaw,
    output logic             frameDone
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hNext;
    logic [CNT_W-1:0] vNext;

    // Next raster position: step the column, wrap into the next line, wrap the frame.
    always_comb begin
        hNext = hCount + 10'd1;
        vNext = vCount;
        if (hCount == H_LAST) begin
            hNext = {CNT_W{1'b0}};
            if (vCount == V_LAST) begin
                vNext = {CNT_W{1'b0}};
            end else begin
                vNext = vCount + 10'd1;
            end
        end else begin
            hNext = hCount + 10'd1;
            vNext = vCount;
        end
    end

    // Counter registers; frameDone is decoded from the next position so it coincides with (0, V_ACTIVE).
    always_ff @(posedge clk25) begin
        if (!rstN) begin
            hCount    <= {CNT_W{1'b0}};
            vCount    <= {CNT_W{1'b0}};
            frameDone <= 1'b0;
        end else begin
            hCount    <= hNext;
            vCount    <= vNext;
            frameDone <= (hNext == {CNT_W{1'b0}}) && (vNext == V_ACT_C);
        end
    end

    // Undelayed visible-area and sync decode.
    always_comb begin
        active   = (hCount < H_ACT_C) && (vCount < V_ACT_C);
        hsyncRaw = ~((hCount >= HS_START) && (hCount < HS_END));
        vsyncRaw = ~((vCount >= VS_START) && (vCount < VS_END));
    end

endmodule

// File: rtl/vga_scan_reader.sv
// vga_scan_reader
//   640x480@60 raster generator that reads a 320x240 RGB444 frame buffer with 2x upscale,
//   hands each pixel and its column to the filter stage, and registers the filtered pixel
//   onto the VGA pins with syncs delayed by the same amount (pin latency RD_LAT+2).
//   Optional feature macro: VGA_TEST_PATTERN_EN (adds patSel and an 8-bar colour pattern).
//   Ports:
//     clk25        in   25 MHz pixel clock
//     rstN         in   synchronous active-low reset
//     patSel       in   test pattern select (only with VGA_TEST_PATTERN_EN)
//     fbAddr       out  frame-buffer read address, 0 outside the visible area
//     fbRdEn       out  read enable, visible area only
//     fbData       in   RGB444 read data, valid RD_LAT cycles after fbAddr
//     xAddrOut     out  column of pixOut
//     pixOut       out  pixel to the filter stage
//     pixValid     out  pixOut/xAddrOut belong to the visible area
//     procPixelIn  in   filtered pixel, combinational from pixOut
//     vgaR/G/B     out  VGA colour nibbles
//     hsync,vsync  out  active-low syncs aligned to the colour
//     frameDone    out  one-cycle pulse at the first vertical blanking line
module vga_scan_reader
    import vga_timing_pkg::*;
#(
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk25,
    input  logic             rstN,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             patSel,
`endif
    output logic [FB_AW-1:0] fbAddr,
    output logic             fbRdEn,
    input  logic [PIX_W-1:0] fbData,
    output logic [CNT_W-1:0] xAddrOut,
    output logic [PIX_W-1:0] pixOut,
    output logic             pixValid,
    input  logic [PIX_W-1:0] procPixelIn,
    output logic [3:0]       vgaR,
    output logic [3:0]       vgaG,
    output logic [3:0]       vgaB,
    output logic             hsync,
    output logic             vsync,
    output logic             frameDone
);

    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             active;
    logic             hsyncRaw;
    logic             vsyncRaw;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) uTiming (
        .clk25     (clk25),
        .rstN      (rstN),
        .hCount    (hCount),
        .vCount    (vCount),
        .active    (active),
        .hsyncRaw  (hsyncRaw),
        .vsyncRaw  (vsyncRaw),
        .frameDone (frameDone)
    );

    // Stage 0: frame-buffer address. Halving both coordinates gives the 2x upscale;
    // y*320 is built from two shifts so no multiplier is needed.
    logic [CNT_W-1:0] yHalf;
    logic [CNT_W-1:0] xHalf;
    logic [FB_AW-1:0] yExt;
    logic [FB_AW-1:0] rowBase;

    // Address math, forced to 0 outside the visible area.
    always_comb begin
        yHalf   = vCount >> 1;
        xHalf   = hCount >> 1;
        yExt    = {{(FB_AW - CNT_W){1'b0}}, yHalf};
        rowBase = (yExt << 8) + (yExt << 6);
        if (active) begin
            fbAddr = rowBase + {{(FB_AW - CNT_W){1'b0}}, xHalf};
        end else begin
            fbAddr = {FB_AW{1'b0}};
        end
    end

    // Read enable: visible area only, and never while the test pattern replaces the buffer.
    always_comb begin
        fbRdEn = active;
`ifdef VGA_TEST_PATTERN_EN
        if (patSel) begin
            fbRdEn = 1'b0;
        end else begin
            fbRdEn = active;
        end
`endif
    end

    // Delay pipes: active/column track the BRAM latency; syncs run one stage further
    // (RD_LAT+1 here plus the pin register) so they line up with the RGB.
    logic             activePipe [RD_LAT];
    logic [CNT_W-1:0] hPipe      [RD_LAT];
    logic [1:0]       syncPipe   [RD_LAT+1];

    // Shift the delay pipes; reset clears active and parks syncs inactive so no partial pulse escapes.
    always_ff @(posedge clk25) begin
        if (!rstN) begin
            for (int i = 0; i < RD_LAT; i++) begin
                activePipe[i] <= 1'b0;
                hPipe[i]      <= {CNT_W{1'b0}};
            end
            for (int i = 0; i < RD_LAT + 1; i++) begin
                syncPipe[i] <= 2'b11;
            end
        end else begin
            activePipe[0] <= active;
            hPipe[0]      <= hCount;
            for (int i = 1; i < RD_LAT; i++) begin
                activePipe[i] <= activePipe[i-1];
                hPipe[i]      <= hPipe[i-1];
            end
            syncPipe[0] <= {hsyncRaw, vsyncRaw};
            for (int i = 1; i < RD_LAT + 1; i++) begin
                syncPipe[i] <= syncPipe[i-1];
            end
        end
    end

    logic             activeL;
    logic [CNT_W-1:0] hL;
    logic [PIX_W-1:0] pixSrc;

    // Pixel source for stage L: the frame buffer, or the colour bars when selected.
    always_comb begin
        activeL = activePipe[RD_LAT-1];
        hL      = hPipe[RD_LAT-1];
        pixSrc  = fbData;
`ifdef VGA_TEST_PATTERN_EN
        if (patSel) begin
            pixSrc = barColour(barIndex(hL));
        end else begin
            pixSrc = fbData;
        end
`endif
    end

    // Stage L: capture the pixel. In blanking pixOut/xAddrOut hold so the filter's
    // line buffer only ever sees in-range columns with their own data.
    always_ff @(posedge clk25) begin
        if (!rstN) begin
            pixOut   <= {PIX_W{1'b0}};
            xAddrOut <= {CNT_W{1'b0}};
            pixValid <= 1'b0;
        end else if (activeL) begin
            pixOut   <= pixSrc;
            xAddrOut <= hL;
            pixValid <= 1'b1;
        end else begin
            pixValid <= 1'b0;
        end
    end

    // Stage L+1: filtered pixel onto the pins (black in blanking), syncs from the end of their pipe.
    always_ff @(posedge clk25) begin
        if (!rstN) begin
            vgaR  <= 4'd0;
            vgaG  <= 4'd0;
            vgaB  <= 4'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            if (pixValid) begin
                vgaR <= procPixelIn[11:8];
                vgaG <= procPixelIn[7:4];
                vgaB <= procPixelIn[3:0];
            end else begin
                vgaR <= 4'd0;
                vgaG <= 4'd0;
                vgaB <= 4'd0;
            end
            hsync <= syncPipe[RD_LAT][1];
            vsync <= syncPipe[RD_LAT][0];
        end
    end

endmodule

// File: tb/tb_vga_scan_reader.sv
// Testbench for vga_scan_reader. Full horizontal timing, shortened vertical timing
// (8 visible lines) so that several whole frames fit in a short run; RD_LAT = 2.
// The BRAM model returns addr[11:0]; procPixelIn is looped back from pixOut.
module tb_vga_scan_reader;

    localparam int RL  = 2;
    localparam int HT  = 800;
    localparam int HA  = 640;
    localparam int HSS = 656;
    localparam int HSE = 752;
    localparam int HSW = 96;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int VSS = VA + VFP;
    localparam int VSE = VSS + VSW;
    localparam int LAT = RL + 2;

    logic        clk25 = 1'b0;
    logic        rstN;
    logic [16:0] fbAddr;
    logic        fbRdEn;
    logic [11:0] fbData;
    logic [9:0]  xAddrOut;
    logic [11:0] pixOut;
    logic        pixValid;
    logic [11:0] procPixelIn;
    logic [3:0]  vgaR, vgaG, vgaB;
    logic        hsync, vsync, frameDone;
`ifdef VGA_TEST_PATTERN_EN
    logic        patSel;
`endif

    bit patMode = 1'b0;
    int seg     = 0;
    int total   = 0;
    int bad     = 0;

    always #5 clk25 = ~clk25;

    vga_scan_reader #(
        .RD_LAT   (RL),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSW),
        .V_BP     (VBP)
    ) dut (
        .clk25       (clk25),
        .rstN        (rstN),
`ifdef VGA_TEST_PATTERN_EN
        .patSel      (patSel),
`endif
        .fbAddr      (fbAddr),
        .fbRdEn      (fbRdEn),
        .fbData      (fbData),
        .xAddrOut    (xAddrOut),
        .pixOut      (pixOut),
        .pixValid    (pixValid),
        .procPixelIn (procPixelIn),
        .vgaR        (vgaR),
        .vgaG        (vgaG),
        .vgaB        (vgaB),
        .hsync       (hsync),
        .vsync       (vsync),
        .frameDone   (frameDone)
    );

`ifdef VGA_TEST_PATTERN_EN
    assign patSel = patMode;
`endif

    // BRAM model: RL-cycle read latency, data = address low 12 bits
    logic [11:0] bram [RL];
    always @(posedge clk25) begin
        if (fbRdEn) bram[0] <= fbAddr[11:0];
        for (int i = 1; i < RL; i++) bram[i] <= bram[i-1];
    end
    assign fbData      = bram[RL-1];
    assign procPixelIn = pixOut;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- reference model: raster position arithmetic ----
    function automatic int addrOf(input int h, input int v);
        return (v / 2) * 320 + h / 2;
    endfunction

    function automatic int barRef(input int x);
        case (x / 80)
            0: return 32'hFFF;
            1: return 32'hFF0;
            2: return 32'h0FF;
            3: return 32'h0F0;
            4: return 32'hF0F;
            5: return 32'hF00;
            6: return 32'h00F;
            default: return 32'h000;
        endcase
    endfunction

    function automatic int pixRef(input int h, input int v, input bit pm);
        return pm ? barRef(h) : (addrOf(h, v) % 4096);
    endfunction

    // posedges with rstN high since the last reset posedge = raster position index
    int sinceRst = 0;
    bit armed    = 1'b0;
    always @(posedge clk25) begin
        if (rstN === 1'b1) sinceRst <= sinceRst + 1;
        else begin
            sinceRst <= 0;
            armed    <= 1'b1;
        end
    end

    int   hsFallP = -1, vsFallP = -1;
    int   hsWidths = 0, vsWidths = 0, vsPeriods = 0, frames = 0, firstHsChecks = 0;
    bit   firstHsPending = 1'b1;
    logic prevHs = 1'b1, prevVs = 1'b1;

    // Compare process: every cycle, at the falling edge
    always @(negedge clk25) begin
        int p, h, v, q1, h1, v1, lh, lv, q2, h2, v2;
        bit a0, a1, a2;
        logic [11:0] rgb;
        if (armed) begin
            p   = sinceRst;
            rgb = {vgaR, vgaG, vgaB};
            h = p % HT;  v = (p / HT) % VT;
            a0 = (h < HA) && (v < VA);
            check("fbRdEn", 32'(a0 && !patMode), 32'(fbRdEn));
            check("fbAddr", 32'(fbAddr), a0 ? addrOf(h, v) : 0);
            check("frameDone", 32'(frameDone), 32'(h == 0 && v == VA));

            q1 = p - (RL + 1);
            if (q1 < 0) begin
                check("pixValid_rst", 32'(pixValid), 0);
                check("pixOut_rst", 32'(pixOut), 0);
                check("xAddr_rst", 32'(xAddrOut), 0);
            end else begin
                h1 = q1 % HT;  v1 = (q1 / HT) % VT;
                a1 = (h1 < HA) && (v1 < VA);
                if (v1 >= VA)      begin lh = HA - 1; lv = VA - 1; end
                else if (h1 >= HA) begin lh = HA - 1; lv = v1;     end
                else               begin lh = h1;     lv = v1;     end
                check("pixValid", 32'(pixValid), 32'(a1));
                check("pixOut", 32'(pixOut), pixRef(lh, lv, patMode));
                check("xAddrOut", 32'(xAddrOut), lh);
                if (patMode && a1 && h1 == 0)   check("bar_x0", 32'(pixOut), 32'hFFF);
                if (patMode && a1 && h1 == 80)  check("bar_x80", 32'(pixOut), 32'hFF0);
                if (patMode && a1 && h1 == 600) check("bar_x600", 32'(pixOut), 32'h000);
            end

            q2 = p - LAT;
            if (q2 < 0) begin
                check("rgb_rst", 32'(rgb), 0);
                check("hsync_rst", 32'(hsync), 1);
                check("vsync_rst", 32'(vsync), 1);
            end else begin
                h2 = q2 % HT;  v2 = (q2 / HT) % VT;
                a2 = (h2 < HA) && (v2 < VA);
                check("rgb", 32'(rgb), a2 ? pixRef(h2, v2, patMode) : 0);
                check("hsync", 32'(hsync), 32'(!(h2 >= HSS && h2 < HSE)));
                check("vsync", 32'(vsync), 32'(!(v2 >= VSS && v2 < VSE)));
            end

            // hand-computed pins for the first segment
            if (seg == 0 && p == 2)    check("addr_2_0", 32'(fbAddr), 32'd1);
            if (seg == 0 && p == 639)  check("addr_639_0", 32'(fbAddr), 32'd319);
            if (seg == 0 && p == 6239) check("addr_639_7", 32'(fbAddr), 32'd1279);
            if (seg == 0 && p == 640)  check("rdEn_640", 32'(fbRdEn), 32'd0);
            if (seg == 0 && p == 6)    check("rgb_2_0", 32'(rgb), 32'h001);
            if (seg == 0 && p == 2408) check("rgb_4_3", 32'(rgb), 32'h142);
            if (seg == 0 && p == 704)  check("rgb_700_0", 32'(rgb), 32'h000);
            if (seg == 0 && p >= 643 && p < 803) begin
                check("hold_x", 32'(xAddrOut), 32'd639);
                check("hold_pix", 32'(pixOut), 32'h13F);
                check("hold_valid", 32'(pixValid), 32'd0);
            end

            // sync edge bookkeeping
            if (p == 0) begin
                hsFallP = -1;  vsFallP = -1;  firstHsPending = 1'b1;
            end else begin
                if (prevHs && !hsync) begin
                    if (firstHsPending) begin
                        check("firstHsFall", p, 660);  // 656 + RD_LAT + 2
                        firstHsPending = 1'b0;
                        firstHsChecks++;
                    end
                    hsFallP = p;
                end
                if (!prevHs && hsync && hsFallP >= 0) begin
                    check("hsWidth", p - hsFallP, HSW);
                    hsWidths++;
                end
                if (prevVs && !vsync) begin
                    if (vsFallP >= 0) begin
                        check("vsPeriod", p - vsFallP, HT * VT);
                        vsPeriods++;
                    end
                    vsFallP = p;
                end
                if (!prevVs && vsync && vsFallP >= 0) begin
                    check("vsWidth", p - vsFallP, VSW * HT);
                    vsWidths++;
                end
            end
            if (frameDone) frames++;
            prevHs = hsync;
            prevVs = vsync;
        end
    end

    initial begin
        rstN = 1'b0;
        repeat (5) @(posedge clk25);
        #2 rstN = 1'b1;

        // two frames plus part of a line, ending inside an hsync pulse
        repeat (24700) @(posedge clk25);
        #2;
        check("frames_seg0", frames, 2);
        check("vsPeriods_seg0", vsPeriods, 1);
        check("vsWidths_seg0", vsWidths, 2);
        check("hsWidths_seg0", hsWidths, 30);
        check("firstHs_seg0", firstHsChecks, 1);

        // mid-line reset; the raster must restart cleanly at (0,0)
        rstN = 1'b0;
        seg  = 1;
`ifdef VGA_TEST_PATTERN_EN
        patMode = 1'b1;
`endif
        repeat (3) @(posedge clk25);
        #2 rstN = 1'b1;
        repeat (1500) @(posedge clk25);
        #2;
        check("firstHs_seg1", firstHsChecks, 2);
        check("frames_seg1", frames, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
